// File: rtl/branch_redirect_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for the front-end PC sequencer.
//   br_kind_t : encoding of the resolved branch kind from the execute stage
//   state_t   : sequencer states (BOOT, RUN, FLUSH)
//   PC_STEP   : byte distance between sequential fetches
//   FLUSH_CNT_W : width of the squash counter (holds 1..7)
// ---------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JIMM = 2'b01,
        BR_JREG = 2'b10,
        BR_RSVD = 2'b11
    } br_kind_t;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } state_t;

    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/branch_redirect_unit_target.sv
// ---------------------------------------------------------------------------
// branch_target
// Purely combinational redirect target computation and alignment check.
// Ports:
//   i_br_kind     : branch kind (conditional, jump-imm, jump-reg, reserved)
//   i_br_pc       : PC of the branch instruction
//   i_br_offset   : sign-extended word offset (conditional / jump-imm)
//   i_br_reg      : register target (jump-reg)
//   o_target      : redirect address, always word aligned for jump-reg
//   o_misaligned  : jump-reg target had nonzero low bits
// ---------------------------------------------------------------------------
module branch_target
    import branch_pkg::*;
(
    input  br_kind_t    i_br_kind,
    input  logic [31:0] i_br_pc,
    input  logic [31:0] i_br_offset,
    input  logic [31:0] i_br_reg,
    output logic [31:0] o_target,
    output logic        o_misaligned
);

    // Word offset becomes a byte offset by dropping its top two bits; the
    // sum then wraps modulo 2^32 like every other PC computation.
    logic [31:0] w_relTarget;
    assign w_relTarget = i_br_pc + PC_STEP + {i_br_offset[29:0], 2'b00};

    // Jump-register targets are forced to word alignment; the dropped bits
    // are reported separately so the top level can flag the fault.
    always_comb begin
        o_target     = w_relTarget;
        o_misaligned = 1'b0;
        if (i_br_kind == BR_JREG) begin
            o_target     = {i_br_reg[31:2], 2'b00};
            o_misaligned = (i_br_reg[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// ---------------------------------------------------------------------------
// branch_redirect_unit
// Front-end PC sequencer. Holds the fetch PC, steps it sequentially, accepts
// one resolved branch per cycle and, on a taken branch/jump, redirects the PC
// and squashes wrong-path fetches for FLUSH_CYCLES cycles.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_stall         : fetch back-pressure, freezes sequential advance
//   i_br_valid      : resolved branch presented this cycle
//   i_br_kind       : 00 cond, 01 jump-imm, 10 jump-reg, 11 reserved
//   i_bcres         : condition result (conditional kind only)
//   i_br_pc         : PC of the branch
//   i_br_offset     : sign-extended word offset
//   i_br_reg        : register target
//   o_pc            : current fetch address
//   o_fetch_valid   : o_pc is a valid fetch
//   o_flush         : squash younger in-flight instructions
//   o_align_err     : sticky jump-register misalignment flag
//   o_taken_cnt     : count of taken redirects, wraps at 2^16
// ---------------------------------------------------------------------------
module branch_redirect_unit
    import branch_pkg::*;
#(
    parameter logic [31:0] PC_RESET     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_br_valid,
    input  logic [1:0]  i_br_kind,
    input  logic        i_bcres,
    input  logic [31:0] i_br_pc,
    input  logic [31:0] i_br_offset,
    input  logic [31:0] i_br_reg,
    output logic [31:0] o_pc,
    output logic        o_fetch_valid,
    output logic        o_flush,
    output logic        o_align_err,
    output logic [15:0] o_taken_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

    br_kind_t               w_kind;
    logic                   w_taken;
    logic [31:0]            w_target;
    logic                   w_misaligned;

    state_t                 r_state;
    logic [31:0]            r_pc;
    logic                   r_fetchValid;
    logic                   r_flush;
    logic                   r_alignErr;
    logic [15:0]            r_takenCnt;
    logic [FLUSH_CNT_W-1:0] r_flushCnt;

    assign w_kind = br_kind_t'(i_br_kind);

    branch_target u_target (
        .i_br_kind    (w_kind),
        .i_br_pc      (i_br_pc),
        .i_br_offset  (i_br_offset),
        .i_br_reg     (i_br_reg),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    // Reserved kind never redirects; the condition result only matters for
    // conditional branches.
    always_comb begin
        w_taken = 1'b0;
        case (w_kind)
            BR_COND: w_taken = i_bcres;
            BR_JIMM: w_taken = 1'b1;
            BR_JREG: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    // Sequencer FSM. Every output is a register written alongside the state
    // so that what is visible after an edge already describes the new state.
    // A taken branch wins over stall. In FLUSH the counter holds the number
    // of squash cycles still to show including the current one, so leaving
    // when it reads 1 gives exactly FLUSH_CYCLES cycles of flush.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= BOOT;
            r_pc         <= PC_RESET;
            r_fetchValid <= 1'b0;
            r_flush      <= 1'b0;
            r_alignErr   <= 1'b0;
            r_takenCnt   <= 16'd0;
            r_flushCnt   <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state      <= RUN;
                    r_fetchValid <= 1'b1;
                end
                RUN: begin
                    if (i_br_valid && w_taken) begin
                        r_state      <= FLUSH;
                        r_pc         <= w_target;
                        r_fetchValid <= 1'b0;
                        r_flush      <= 1'b1;
                        r_takenCnt   <= r_takenCnt + 16'd1;
                        r_flushCnt   <= FLUSH_LOAD;
                        if (w_misaligned) begin
                            r_alignErr <= 1'b1;
                        end
                    end else if (!i_stall) begin
                        r_pc <= r_pc + PC_STEP;
                    end
                end
                FLUSH: begin
                    if (r_flushCnt <= FLUSH_CNT_W'(1)) begin
                        r_state      <= RUN;
                        r_fetchValid <= 1'b1;
                        r_flush      <= 1'b0;
                        r_flushCnt   <= '0;
                    end else begin
                        r_flushCnt <= r_flushCnt - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    r_state      <= BOOT;
                    r_pc         <= PC_RESET;
                    r_fetchValid <= 1'b0;
                    r_flush      <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_fetch_valid = r_fetchValid;
    assign o_flush       = r_flush;
    assign o_align_err   = r_alignErr;
    assign o_taken_cnt   = r_takenCnt;

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Front-end PC sequencer and consumer of the branch-condition result. It holds the architectural fetch PC, advances it sequentially, and accepts one resolved branch per cycle from the execute stage. On a taken branch or jump it redirects the PC and squashes wrong-path fetches for a fixed number of cycles. It sits between the branch-condition evaluator (execute stage) and the instruction fetch/IMEM port.

## Interface
- PC_RESET, 32'h0000_0000: PC value loaded by reset.
- FLUSH_CYCLES, 2: cycles of wrong-path squash after a redirect; legal range 1–7.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  fetch back-pressure; freezes PC advance.
- br_valid  in  1  a resolved branch/jump is presented this cycle.
- br_kind  in  2  00 conditional, 01 jump-immediate, 10 jump-register, 11 reserved (treated as not taken).
- bcres  in  1  condition result from the evaluator; meaningful only for kind 00.
- br_pc  in  32  PC of the branch instruction.
- br_offset  in  32  sign-extended word offset, for kinds 00 and 01.
- br_reg  in  32  register target, for kind 10.
- pc  out  32  current fetch address.
- fetch_valid  out  1  pc is a valid fetch this cycle.
- flush  out  1  squash younger in-flight instructions.
- align_err  out  1  sticky; jump-register target had bits[1:0] ≠ 0.
- taken_cnt  out  16  number of taken redirects, wraps modulo 2^16.

## Operation
- States: BOOT, RUN, FLUSH.
- BOOT: entered on reset and lasts one cycle; pc = PC_RESET, fetch_valid = 0. Always moves to RUN.
- RUN: fetch_valid = 1.
  - If stall = 0, pc ← pc + 4.
  - If stall = 1, pc holds.
- Taken condition: (kind 00 and bcres = 1), or kind 01, or kind 10.
- Target:
  - Kinds 00/01: br_pc + 4 + (br_offset << 2).
  - Kind 10: {br_reg[31:2], 2'b00}. If br_reg[1:0] ≠ 0, set align_err.
  - All arithmetic is 32-bit, modulo 2^32; overflow wraps silently.
- Branch in RUN with br_valid = 1 and taken:
  - pc ← target; stall is ignored for that cycle.
  - taken_cnt increments.
  - Flush counter is loaded with FLUSH_CYCLES.
  - Next state is FLUSH.
- Branch in RUN with br_valid = 1 and not taken: behaves as a normal RUN cycle.
- FLUSH: flush = 1, fetch_valid = 0, pc holds the target.
  - The counter decrements every cycle regardless of stall.
  - When the counter reaches 1, the next state is RUN.
  - br_valid is ignored in FLUSH because it is wrong-path.
- rst takes priority over everything and restores every reset value, including mid-FLUSH.

## Timing
- Reset values: pc = PC_RESET, fetch_valid = 0, flush = 0, align_err = 0, taken_cnt = 0, state = BOOT.
- Redirect latency:
  - Branch sampled at edge N.
  - pc = target and flush = 1 from edge N through edge N+FLUSH_CYCLES.
  - fetch_valid returns to 1 at edge N+FLUSH_CYCLES with pc = target.
  - First sequential advance to target + 4 happens at the following unstalled edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- br_valid and stall high together in RUN: a taken branch redirects; a not-taken branch holds pc.
- Branch target equal to the current pc is legal; it still causes a full flush.

## Structure
- Package branch_pkg:
  - br_kind_t enum (BR_COND, BR_JIMM, BR_JREG, BR_RSVD).
  - state_t enum (BOOT, RUN, FLUSH).
  - PC_STEP = 4.
- Sub-module branch_target: purely combinational target computation and alignment check. It takes br_kind, br_pc, br_offset and br_reg, and returns target and misaligned.

## Test plan
- Reset, then 3 unstalled cycles:
  - pc sequence is 0 (BOOT), 0, 4, 8.
  - fetch_valid is 0 in BOOT, then 1.
- Conditional taken (br_pc = 0x100, br_offset = 3, bcres = 1):
  - pc = 0x110.
  - flush = 1 for exactly 2 cycles.
  - taken_cnt = 1.
  - Next fetched addresses are 0x110, then 0x114.
- Conditional not taken (bcres = 0) and kind 11: no flush, pc keeps stepping by 4, taken_cnt unchanged.
- Jump-register br_reg = 0x2003:
  - pc = 0x2000 and align_err = 1.
  - align_err stays set across later branches until rst.
- br_valid with stall = 1: taken branch redirects immediately; a second br_valid during FLUSH is ignored and pc stays at the first target.
- rst asserted mid-FLUSH: next cycle pc = PC_RESET, flush = 0, taken_cnt = 0, state BOOT. Also covers br_offset = −1 from br_pc = 0: target 0x0000_0000 (wraps).
